ram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sits directly upstream of the simple single-write/async-read RAM and owns its ports. It manages the write address/data/enable and the read address. It turns the RAM into a show-ahead FIFO with valid/ready handshakes on both sides. It also provides occupancy, almost-full and a high-watermark for debug.

---
 rtl/ram_fifo_pkg.sv | 17 +
 rtl/ram_fifo_ctrl_if.sv | 36 +++
 rtl/ram_fifo_ptr.sv | 24 ++
 rtl/ram_fifo_ctrl.sv | 95 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared helpers and types for the RAM-backed FIFO controller.
// Default widths here only size the wrap-pointer struct; modules take their own parameters.
package ram_fifo_pkg;

    localparam int AWIDTH_DEF = 4;
    localparam int DWIDTH_DEF = 4;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

    typedef struct packed {
        logic                  wrap;
        logic [AWIDTH_DEF-1:0] addr;
    } wrap_ptr_t;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Bundle of producer, consumer, RAM and status signals around the FIFO controller.
// master = the controller itself, slave = everything connected around it.
interface ram_fifo_ctrl_if #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 4
);

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_data;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_wraddr;
    logic [DWIDTH-1:0] mem_wrdata;
    logic [AWIDTH-1:0] mem_rdaddr;
    logic [DWIDTH-1:0] mem_rddata;
    logic [AWIDTH:0]   count;
    logic              almost_full;
    logic [AWIDTH:0]   max_count;

    modport master (
        input  flush, in_valid, in_data, out_ready, mem_rddata,
        output in_ready, out_valid, out_data, mem_we, mem_wraddr, mem_wrdata,
               mem_rdaddr, count, almost_full, max_count
    );

    modport slave (
        output flush, in_valid, in_data, out_ready, mem_rddata,
        input  in_ready, out_valid, out_data, mem_we, mem_wraddr, mem_wrdata,
               mem_rdaddr, count, almost_full, max_count
    );

endinterface

// File: rtl/ram_fifo_ptr.sv
// Wrap pointer: AWIDTH address bits plus one wrap bit, with increment and synchronous clear.
module ram_fifo_ptr #(
    parameter int AWIDTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            inc,
    output logic [AWIDTH:0] ptr
);

    localparam logic [AWIDTH:0] PTR_ONE = 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Show-ahead FIFO controller that owns the ports of a single-write/async-read RAM.
// Tracks occupancy, a registered almost-full flag and a high-watermark for debug.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int AWIDTH      = 4,
    parameter int DWIDTH      = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_fifo_ctrl_if.master bus
);

    localparam int DEPTH       = depth(AWIDTH);
    localparam int AFULL_CLAMP = (AFULL_LEVEL > DEPTH) ? DEPTH :
                                 ((AFULL_LEVEL < 1) ? 1 : AFULL_LEVEL);
    localparam logic [AWIDTH:0] AFULL_THR = AFULL_CLAMP[AWIDTH:0];
    localparam logic [AWIDTH:0] CNT_ONE   = 1;

    logic [AWIDTH:0] wr_ptr;
    logic [AWIDTH:0] rd_ptr;
    logic [AWIDTH:0] count_q;
    logic [AWIDTH:0] count_next;
    logic [AWIDTH:0] max_q;
    logic            afull_q;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]) &&
                   (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]);

    // Flush gates both handshakes so nothing moves in the clearing cycle.
    assign bus.in_ready  = !full && !bus.flush;
    assign bus.out_valid = !empty && !bus.flush;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    assign bus.out_data    = bus.mem_rddata;
    assign bus.mem_we      = push;
    assign bus.mem_wraddr  = wr_ptr[AWIDTH-1:0];
    assign bus.mem_wrdata  = bus.in_data;
    assign bus.mem_rdaddr  = rd_ptr[AWIDTH-1:0];
    assign bus.count       = count_q;
    assign bus.almost_full = afull_q;
    assign bus.max_count   = max_q;

    ram_fifo_ptr #(.AWIDTH(AWIDTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (bus.flush),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    ram_fifo_ptr #(.AWIDTH(AWIDTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (bus.flush),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    always_comb begin
        count_next = count_q;
        if (push && !pop) begin
            count_next = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count_q - CNT_ONE;
        end
    end

    // Flags follow the next count so they line up with count in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            max_q   <= '0;
            afull_q <= 1'b0;
        end else if (bus.flush) begin
            count_q <= '0;
            max_q   <= '0;
            afull_q <= 1'b0;
        end else begin
            count_q <= count_next;
            afull_q <= (count_next >= AFULL_THR);
            if (count_next > max_q) begin
                max_q <= count_next;
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural async-read RAM attached.
module tb_ram_fifo_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ram_fifo_ctrl_if #(.AWIDTH(4), .DWIDTH(4)) bus ();

    ram_fifo_ctrl #(.AWIDTH(4), .DWIDTH(4), .AFULL_LEVEL(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [3:0] mem [16];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_wraddr] <= bus.mem_wrdata;
        end
    end

    assign bus.mem_rddata = mem[bus.mem_rdaddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic iv, input logic [3:0] id,
                                  input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        #11;
        check_output("rst_count", 32'(bus.count), 32'd0);
        check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_output("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check_output("rst_almost_full", 32'(bus.almost_full), 32'd0);
        check_output("rst_max_count", 32'(bus.max_count), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] filling FIFO with 16 words");
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 4'((4'hA + i) & 4'hF), 1'b0, 1'b0);
            check_output("fill_in_ready", 32'(bus.in_ready), 32'd1);
            check_output("fill_mem_we", 32'(bus.mem_we), 32'd1);
            check_output("fill_wraddr", 32'(bus.mem_wraddr), 32'(i));
            check_output("fill_out_valid", 32'(bus.out_valid), (i != 0) ? 32'd1 : 32'd0);
            tick();
            check_output("fill_count", 32'(bus.count), 32'(i + 1));
            check_output("fill_almost_full", 32'(bus.almost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
        end
        apply_stimulus(1'b1, 4'h3, 1'b0, 1'b0);
        check_output("full_in_ready", 32'(bus.in_ready), 32'd0);
        check_output("full_mem_we", 32'(bus.mem_we), 32'd0);
        check_output("full_wraddr_wrapped", 32'(bus.mem_wraddr), 32'd0);
        tick();
        check_output("full_count", 32'(bus.count), 32'd16);
        check_output("full_max_count", 32'(bus.max_count), 32'd16);

        $display("[TB] draining FIFO");
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b0, 4'h0, 1'b1, 1'b0);
            check_output("drain_out_valid", 32'(bus.out_valid), 32'd1);
            check_output("drain_out_data", 32'(bus.out_data), 32'((4'hA + i) & 4'hF));
            tick();
            check_output("drain_count", 32'(bus.count), 32'(15 - i));
            check_output("drain_almost_full", 32'(bus.almost_full), (15 - i >= 12) ? 32'd1 : 32'd0);
        end
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        check_output("empty_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("empty_in_ready", 32'(bus.in_ready), 32'd1);
        check_output("empty_max_count", 32'(bus.max_count), 32'd16);

        $display("[TB] single push latency");
        apply_stimulus(1'b1, 4'h5, 1'b0, 1'b0);
        check_output("lat_no_bypass", 32'(bus.out_valid), 32'd0);
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        check_output("lat_out_valid", 32'(bus.out_valid), 32'd1);
        check_output("lat_out_data", 32'(bus.out_data), 32'h5);
        check_output("lat_count", 32'(bus.count), 32'd1);

        for (int i = 1; i < 8; i++) begin
            apply_stimulus(1'b1, 4'(i), 1'b0, 1'b0);
            tick();
        end
        check_output("pre_stream_count", 32'(bus.count), 32'd8);

        $display("[TB] streaming push+pop at count 8");
        for (int k = 0; k < 20; k++) begin
            apply_stimulus(1'b1, 4'((8 + k) & 15), 1'b1, 1'b0);
            check_output("stream_mem_we", 32'(bus.mem_we), 32'd1);
            check_output("stream_wraddr", 32'(bus.mem_wraddr), 32'((8 + k) & 15));
            check_output("stream_rdaddr", 32'(bus.mem_rdaddr), 32'(k & 15));
            check_output("stream_out_data", 32'(bus.out_data), (k == 0) ? 32'h5 : 32'(k & 15));
            tick();
            check_output("stream_count", 32'(bus.count), 32'd8);
        end
        check_output("stream_max_count", 32'(bus.max_count), 32'd16);

        apply_stimulus(1'b1, 4'hC, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 4'hD, 1'b0, 1'b0);
        tick();
        check_output("pre_flush_count", 32'(bus.count), 32'd10);

        $display("[TB] flush with both handshakes requested");
        apply_stimulus(1'b1, 4'hE, 1'b1, 1'b1);
        check_output("flush_in_ready", 32'(bus.in_ready), 32'd0);
        check_output("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("flush_mem_we", 32'(bus.mem_we), 32'd0);
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        check_output("post_flush_count", 32'(bus.count), 32'd0);
        check_output("post_flush_max", 32'(bus.max_count), 32'd0);
        check_output("post_flush_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("post_flush_almost_full", 32'(bus.almost_full), 32'd0);
        check_output("post_flush_wraddr", 32'(bus.mem_wraddr), 32'd0);
        check_output("post_flush_in_ready", 32'(bus.in_ready), 32'd1);

        $display("[TB] async reset mid-cycle at count 6");
        for (int i = 1; i <= 6; i++) begin
            apply_stimulus(1'b1, 4'(i), 1'b0, 1'b0);
            tick();
        end
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        check_output("pre_rst_count", 32'(bus.count), 32'd6);
        check_output("pre_rst_max", 32'(bus.max_count), 32'd6);
        check_output("pre_rst_head", 32'(bus.out_data), 32'h1);
        rst_n = 1'b0;
        #1;
        check_output("async_rst_count", 32'(bus.count), 32'd0);
        check_output("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_output("async_rst_max", 32'(bus.max_count), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        apply_stimulus(1'b1, 4'h9, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        check_output("after_rst_count", 32'(bus.count), 32'd1);
        check_output("after_rst_out_data", 32'(bus.out_data), 32'h9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
